spi_xfer_ctrl: RTL and testbench
================================

# spi_xfer_ctrl

SPI master transfer sequencer. It accepts a one-word transfer request from the AXI-side register logic and generates chip select, SCLK, MOSI and MISO sampling for exactly one word. SCLK is derived internally from a half-period counter, so any even division ratio, including 2, 4 and 8, is supported. The block sits between the AXI register file and the SPI pads and is the sole owner of the SPI bus timing.

## Interface
- g_clk_div, 4: clk_i cycles per SCLK period. Must be even and ≥2.
- g_data_width, 8: bits per transfer, 1..32.
- g_cs_setup, 2: clk_i cycles from cs_n_o falling to the first SCLK edge. Must be ≥1.
- g_cs_hold, 2: clk_i cycles from the last SCLK edge to cs_n_o rising. Must be ≥1.
- clk_i  in  1  system clock; one clock domain only.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
- start_i  in  1  transfer request; sampled only in IDLE.
- cpol_i  in  1  SCLK idle level; latched at start.
- cpha_i  in  1  0: sample on the leading edge; 1: sample on the trailing edge. Latched at start.
- tx_data_i  in  g_data_width  word to send; latched at start.
- miso_i  in  1  serial input.
- busy_o  out  1  high from the cycle after start is accepted until the cycle done_o pulses, inclusive of neither.
- done_o  out  1  one-cycle pulse at end of transfer.
- rx_data_o  out  g_data_width  received word; updated in the done_o cycle and held until the next done_o.
- sclk_o  out  1  SPI clock.
- mosi_o  out  1  serial output.
- cs_n_o  out  1  chip select, active-low.

## Operation
- State machine: IDLE → SETUP → XFER → HOLD → IDLE.
- IDLE:
  - cs_n_o=1, busy_o=0, sclk_o follows cpol_i (registered).
  - start_i=1 latches cpol_i, cpha_i and tx_data_i into the shift register, then goes to SETUP.
- SETUP:
  - cs_n_o=0, busy_o=1.
  - mosi_o presents the first bit (MSB).
  - Runs g_cs_setup cycles, then goes to XFER.
- XFER:
  - The half-period counter counts 0..g_clk_div/2−1. At terminal count sclk_o toggles and the edge counter increments.
  - Exactly 2·g_data_width edges occur. Odd-numbered edges are leading, even-numbered edges are trailing.
  - CPHA=0: sample miso_i on leading edges; shift the next bit onto mosi_o on trailing edges, except the last one.
  - CPHA=1: shift on leading edges, except the first, which outputs the MSB that was already presented; sample on trailing edges.
  - After the final edge, sclk_o is back at the latched CPOL level. Go to HOLD.
- HOLD:
  - cs_n_o=0, mosi_o holds the last bit.
  - Runs g_cs_hold cycles, then returns to IDLE.
  - On the IDLE-entry cycle: cs_n_o=1, done_o=1, rx_data_o loaded.
- start_i while not in IDLE is ignored (no queueing). start_i held high in the done_o cycle is accepted next cycle, giving back-to-back transfers with a single cs_n_o=1 cycle between words.
- Reset mid-transfer aborts immediately with no done_o pulse. All outputs take reset values asynchronously.
- Reset values: cs_n_o=1, sclk_o=0, mosi_o=0, busy_o=0, done_o=0, rx_data_o=0, state=IDLE.

## Timing
- Start accepted at cycle 0 → cs_n_o low at cycle 1.
- First SCLK edge at cycle 1+g_cs_setup+g_clk_div/2−1.
- cs_n_o low for exactly g_cs_setup + g_data_width·g_clk_div + g_cs_hold cycles.
- done_o occurs in the first cycle with cs_n_o high again.
- miso_i is sampled on the clk_i edge that produces the sampling SCLK edge. No input synchronizer is used; the pad timing constraint covers this path.
- All outputs are registered; there are no combinational paths from input to output.

## Configuration
- SPI_LSB_FIRST_EN defined: adds input lsb_first_i (1 bit, latched at start). When it is 1, bit 0 is shifted out first and received bits fill from the MSB downward. rx_data_o is always delivered in natural bit order.
- SPI_LSB_FIRST_EN undefined: the port is absent and transfers are always MSB-first.

## Test plan
- Parameters div=4, width=8, setup=2, hold=2, CPOL=0, CPHA=0, tx=0xA5, MISO looped to MOSI → cs_n_o low for 36 cycles; 16 SCLK edges, first rising at cycle 4; done_o 1 cycle; rx_data_o=0xA5.
- Modes 1, 2 and 3 with tx=0x3C, slave model returning 0xC3 → rx_data_o=0xC3 in each mode; sclk_o idles at CPOL before and after the transfer.
- div=2, start_i held high for 3 transfers → three done_o pulses, cs_n_o high for exactly 1 cycle between words, busy_o never high together with done_o.
- start_i pulsed during XFER → ignored; exactly one done_o pulse; tx data unchanged.
- rst_n_i asserted at the 5th SCLK edge → cs_n_o=1 and sclk_o=0 immediately; no done_o; the next start completes normally.
- With SPI_LSB_FIRST_EN, lsb_first_i=1, tx=0x01 → mosi_o high on the first bit only; looped rx_data_o=0x01.

Source files
------------

// File: rtl/spi_xfer_ctrl_if.sv
// ----------------------------------------------------------------------------
// spi_xfer_ctrl_if
// Request/response bundle between the register file (master) and the SPI
// transfer sequencer (slave).
//   start_i     : transfer request, sampled while the sequencer is idle
//   cpol_i      : SCLK idle level, latched at start
//   cpha_i      : 0 = sample on leading edge, 1 = sample on trailing edge
//   tx_data_i   : word to send, latched at start
//   lsb_first_i : LSB-first enable (present only with SPI_LSB_FIRST_EN)
//   busy_o      : transfer in progress
//   done_o      : one-cycle end-of-transfer pulse
//   rx_data_o   : received word, valid from the done_o cycle onwards
// Optional feature macro: SPI_LSB_FIRST_EN
// ----------------------------------------------------------------------------
interface spi_xfer_ctrl_if #(
   parameter int unsigned g_data_width = 8
);
   logic                    start_i;
   logic                    cpol_i;
   logic                    cpha_i;
   logic [g_data_width-1:0] tx_data_i;
`ifdef SPI_LSB_FIRST_EN
   logic                    lsb_first_i;
`endif
   logic                    busy_o;
   logic                    done_o;
   logic [g_data_width-1:0] rx_data_o;

   modport master (
      output start_i, cpol_i, cpha_i, tx_data_i,
`ifdef SPI_LSB_FIRST_EN
      output lsb_first_i,
`endif
      input  busy_o, done_o, rx_data_o
   );

   modport slave (
      input  start_i, cpol_i, cpha_i, tx_data_i,
`ifdef SPI_LSB_FIRST_EN
      input  lsb_first_i,
`endif
      output busy_o, done_o, rx_data_o
   );
endinterface

// File: rtl/spi_xfer_ctrl.sv
// ----------------------------------------------------------------------------
// spi_xfer_ctrl
// SPI master sequencer for exactly one word per request. Generates chip
// select, SCLK (from a half-period counter), MOSI and samples MISO.
// Ports:
//   clk_i    : system clock
//   rst_n_i  : asynchronous active-low reset
//   ctrl     : request/response bundle (spi_xfer_ctrl_if.slave)
//   miso_i   : serial input, sampled on the clk_i edge that makes the
//              sampling SCLK edge
//   sclk_o   : SPI clock
//   mosi_o   : serial output
//   cs_n_o   : active-low chip select
// Optional feature macro: SPI_LSB_FIRST_EN (adds ctrl.lsb_first_i).
// All outputs are registered.
// ----------------------------------------------------------------------------
module spi_xfer_ctrl #(
   parameter int unsigned g_clk_div    = 4,
   parameter int unsigned g_data_width = 8,
   parameter int unsigned g_cs_setup   = 2,
   parameter int unsigned g_cs_hold    = 2
) (
   input  logic           clk_i,
   input  logic           rst_n_i,
   spi_xfer_ctrl_if.slave ctrl,
   input  logic           miso_i,
   output logic           sclk_o,
   output logic           mosi_o,
   output logic           cs_n_o
);

   localparam int unsigned W       = g_data_width;
   localparam int unsigned HALF    = g_clk_div / 2;
   localparam int unsigned HCNT_W  = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int unsigned EDGES   = 2 * g_data_width;
   localparam int unsigned EDGE_W  = $clog2(EDGES + 1);
   localparam int unsigned CNT_MAX = (g_cs_setup > g_cs_hold + 1) ? g_cs_setup : g_cs_hold + 1;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_XFER,
      ST_HOLD
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [HCNT_W-1:0]   r_hcnt;
   logic [EDGE_W-1:0]   r_edge;
   logic [W-1:0]        r_sh;
   logic [W-1:0]        r_rx;
   logic [W-1:0]        r_rx_out;
   logic                r_cpha;
   logic                r_lsb;
   logic                r_sclk;
   logic                r_mosi;
   logic                r_cs_n;
   logic                r_busy;
   logic                r_done;

   logic                w_lsb_in;
   logic                w_tick;
   logic [EDGE_W-1:0]   w_edge_num;
   logic                w_leading;
   logic                w_first;
   logic                w_last;
   logic                w_sample;
   logic                w_shift;
   logic [W-1:0]        w_sh_next;
   logic                w_mosi_next;
   logic [W-1:0]        w_rx_next;

`ifdef SPI_LSB_FIRST_EN
   assign w_lsb_in = ctrl.lsb_first_i;
`else
   assign w_lsb_in = 1'b0;
`endif

   // Edge bookkeeping: edges are numbered from 1, odd ones are leading.
   assign w_tick     = (r_hcnt == HCNT_W'(HALF - 1));
   assign w_edge_num = r_edge + EDGE_W'(1);
   assign w_leading  = w_edge_num[0];
   assign w_first    = (r_edge == '0);
   assign w_last     = (r_edge == EDGE_W'(EDGES - 1));

   // CPHA=0 samples on leading / shifts on trailing (never after the last
   // edge); CPHA=1 shifts on leading (not the first, MSB is already out)
   // and samples on trailing.
   assign w_sample = r_cpha ? ~w_leading : w_leading;
   assign w_shift  = r_cpha ? (w_leading & ~w_first) : (~w_leading & ~w_last);

   // Transmit shifter and receive assembly for both bit orders; received
   // bits always end up in natural bit positions.
   assign w_sh_next   = r_lsb ? (r_sh >> 1) : (r_sh << 1);
   assign w_mosi_next = r_lsb ? w_sh_next[0] : w_sh_next[W-1];
   assign w_rx_next   = r_lsb ? ((r_rx >> 1) | (W'(miso_i) << (W - 1)))
                              : ((r_rx << 1) | W'(miso_i));

   // Sequencer. The half-period counter already runs in the cycle after
   // SETUP's last counted cycle, so SETUP itself spans g_cs_setup-1 cycles
   // and HOLD g_cs_hold+1 cycles; this places the first SCLK edge
   // g_cs_setup+g_clk_div/2-1 cycles after cs_n_o falls while keeping
   // cs_n_o low for g_cs_setup+g_data_width*g_clk_div+g_cs_hold cycles.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_hcnt   <= '0;
         r_edge   <= '0;
         r_sh     <= '0;
         r_rx     <= '0;
         r_rx_out <= '0;
         r_cpha   <= 1'b0;
         r_lsb    <= 1'b0;
         r_sclk   <= 1'b0;
         r_mosi   <= 1'b0;
         r_cs_n   <= 1'b1;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_sclk <= ctrl.cpol_i;
               if (ctrl.start_i) begin
                  r_cpha <= ctrl.cpha_i;
                  r_lsb  <= w_lsb_in;
                  r_sh   <= ctrl.tx_data_i;
                  r_mosi <= w_lsb_in ? ctrl.tx_data_i[0] : ctrl.tx_data_i[W-1];
                  r_rx   <= '0;
                  r_cs_n <= 1'b0;
                  r_busy <= 1'b1;
                  r_cnt  <= '0;
                  r_hcnt <= '0;
                  r_edge <= '0;
                  r_state <= (g_cs_setup > 1) ? ST_SETUP : ST_XFER;
               end
            end

            ST_SETUP: begin
               if (r_cnt == CNT_W'(g_cs_setup - 2)) begin
                  r_cnt   <= '0;
                  r_state <= ST_XFER;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            ST_XFER: begin
               if (w_tick) begin
                  r_hcnt <= '0;
                  r_sclk <= ~r_sclk;
                  r_edge <= w_edge_num;
                  if (w_sample) begin
                     r_rx <= w_rx_next;
                  end
                  if (w_shift) begin
                     r_sh   <= w_sh_next;
                     r_mosi <= w_mosi_next;
                  end
                  if (w_last) begin
                     r_cnt   <= '0;
                     r_state <= ST_HOLD;
                  end
               end else begin
                  r_hcnt <= r_hcnt + HCNT_W'(1);
               end
            end

            ST_HOLD: begin
               if (r_cnt == CNT_W'(g_cs_hold)) begin
                  r_cs_n   <= 1'b1;
                  r_busy   <= 1'b0;
                  r_done   <= 1'b1;
                  r_rx_out <= r_rx;
                  r_state  <= ST_IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign sclk_o         = r_sclk;
   assign mosi_o         = r_mosi;
   assign cs_n_o         = r_cs_n;
   assign ctrl.busy_o    = r_busy;
   assign ctrl.done_o    = r_done;
   assign ctrl.rx_data_o = r_rx_out;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_spi_xfer_ctrl
// Directed bench for spi_xfer_ctrl. Instance A: div=4, width=8, setup=2,
// hold=2 with a mode-aware SPI slave model or MOSI loopback. Instance B:
// div=2, loopback, back-to-back transfers. Expected receive words go into
// per-instance queues and are checked by monitors on done_o.
// ----------------------------------------------------------------------------
module tb_spi_xfer_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // ---------------- instance A (div 4) ----------------
   spi_xfer_ctrl_if #(.g_data_width(8)) a_if ();
   logic a_sclk, a_mosi, a_cs_n, a_miso;
   logic sel_loop;
   spi_xfer_ctrl #(.g_clk_div(4), .g_data_width(8), .g_cs_setup(2), .g_cs_hold(2)) u_a (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .ctrl    (a_if),
      .miso_i  (a_miso),
      .sclk_o  (a_sclk),
      .mosi_o  (a_mosi),
      .cs_n_o  (a_cs_n)
   );

   // ---------------- instance B (div 2) ----------------
   spi_xfer_ctrl_if #(.g_data_width(8)) b_if ();
   logic b_sclk, b_mosi, b_cs_n;
   spi_xfer_ctrl #(.g_clk_div(2), .g_data_width(8), .g_cs_setup(2), .g_cs_hold(2)) u_b (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .ctrl    (b_if),
      .miso_i  (b_mosi),
      .sclk_o  (b_sclk),
      .mosi_o  (b_mosi),
      .cs_n_o  (b_cs_n)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- SPI slave model for instance A ----------------
   logic [7:0] s_word, s_sh, s_rx;
   logic       s_bit;
   logic       cur_cpha;
   int         s_edges;

   assign a_miso = sel_loop ? a_mosi : s_bit;

   always @(negedge a_cs_n) begin
      s_sh    = s_word;
      s_bit   = s_word[7];
      s_rx    = 8'h00;
      s_edges = 0;
   end

   always @(a_sclk) begin
      if (a_cs_n === 1'b0) begin
         s_edges++;
         if (s_edges % 2 == 1) begin
            if (!cur_cpha) s_rx = {s_rx[6:0], a_mosi};
            else if (s_edges > 1) begin
               s_sh  = s_sh << 1;
               s_bit = s_sh[7];
            end
         end else begin
            if (cur_cpha) s_rx = {s_rx[6:0], a_mosi};
            else if (s_edges < 16) begin
               s_sh  = s_sh << 1;
               s_bit = s_sh[7];
            end
         end
      end
   end

   // ---------------- scoreboards and monitors ----------------
   logic [7:0] sb_a[$];
   logic [7:0] sb_b[$];
   logic [7:0] exp_a, exp_b;

   always @(negedge clk) begin
      if (rst_n === 1'b1 && a_if.done_o === 1'b1) begin
         if (sb_a.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL a_done_unexpected: got done_o=1, required no pulse");
         end else begin
            exp_a = sb_a.pop_front();
            check("a_rx_data", 32'(a_if.rx_data_o), 32'(exp_a));
            check("a_busy_at_done", 32'(a_if.busy_o), 32'd0);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n === 1'b1 && b_if.done_o === 1'b1) begin
         if (sb_b.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL b_done_unexpected: got done_o=1, required no pulse");
         end else begin
            exp_b = sb_b.pop_front();
            check("b_rx_data", 32'(b_if.rx_data_o), 32'(exp_b));
            check("b_busy_at_done", 32'(b_if.busy_o), 32'd0);
         end
      end
   end

   // ---------------- one transfer on instance A ----------------
   task automatic run_a(input logic cpol, input logic cpha, input logic [7:0] tx,
                        input logic loop, input logic [7:0] slave_word,
                        input logic [7:0] exp_rx, input logic [7:0] exp_cap,
                        input int glitch, input string tag);
      int   cs_low, busy_cnt, first_edge, edges, done_cyc, extra;
      logic prev_sclk;
      @(negedge clk);
      a_if.cpol_i    = cpol;
      a_if.cpha_i    = cpha;
      a_if.tx_data_i = tx;
      cur_cpha       = cpha;
      sel_loop       = loop;
      s_word         = slave_word;
      @(negedge clk);
      check({tag, "_idle_sclk"}, 32'(a_sclk), 32'(cpol));
      a_if.start_i = 1'b1;
      sb_a.push_back(exp_rx);
      @(negedge clk);
      a_if.start_i   = 1'b0;
      a_if.tx_data_i = 8'hFF;
      cs_low = 0; busy_cnt = 0; first_edge = 0; edges = 0; done_cyc = 0;
      prev_sclk = cpol;
      for (int k = 1; k <= 200 && done_cyc == 0; k++) begin
         if (k > 1) @(negedge clk);
         if (k == glitch) begin
            a_if.start_i   = 1'b1;
            a_if.tx_data_i = 8'h00;
         end else begin
            a_if.start_i = 1'b0;
         end
         if (a_cs_n === 1'b0) cs_low++;
         if (a_if.busy_o === 1'b1) busy_cnt++;
         if (a_sclk !== prev_sclk) begin
            edges++;
            if (first_edge == 0) first_edge = k;
            prev_sclk = a_sclk;
         end
         if (a_if.done_o === 1'b1) done_cyc = k;
      end
      a_if.start_i = 1'b0;
      check({tag, "_done_cycle"}, 32'(done_cyc), 32'd37);
      check({tag, "_cs_low_cycles"}, 32'(cs_low), 32'd36);
      check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd36);
      check({tag, "_first_edge_cycle"}, 32'(first_edge), 32'd4);
      check({tag, "_sclk_edges"}, 32'(edges), 32'd16);
      check({tag, "_sclk_after"}, 32'(a_sclk), 32'(cpol));
      check({tag, "_slave_captured_mosi"}, 32'(s_rx), 32'(exp_cap));
      extra = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (a_if.done_o === 1'b1) extra++;
      end
      check({tag, "_extra_done"}, 32'(extra), 32'd0);
      check({tag, "_rx_held"}, 32'(a_if.rx_data_o), 32'(exp_rx));
   endtask

   // ---------------- reset during a transfer ----------------
   task automatic run_reset_abort();
      int   edges, dones;
      logic prev;
      @(negedge clk);
      a_if.cpol_i = 1'b0; a_if.cpha_i = 1'b0; a_if.tx_data_i = 8'h96;
      cur_cpha = 1'b0; sel_loop = 1'b1;
      @(negedge clk);
      a_if.start_i = 1'b1;
      @(negedge clk);
      a_if.start_i = 1'b0;
      edges = 0; prev = 1'b0;
      for (int k = 0; k < 100 && edges < 5; k++) begin
         if (k > 0) @(negedge clk);
         if (a_sclk !== prev) begin
            edges++;
            prev = a_sclk;
         end
      end
      check("rst_reached_edge5", 32'(edges), 32'd5);
      rst_n = 1'b0;
      #1;
      check("rst_cs_n", 32'(a_cs_n), 32'd1);
      check("rst_sclk", 32'(a_sclk), 32'd0);
      check("rst_mosi", 32'(a_mosi), 32'd0);
      check("rst_busy", 32'(a_if.busy_o), 32'd0);
      check("rst_rx_data", 32'(a_if.rx_data_o), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (a_if.done_o === 1'b1) dones++;
      end
      check("rst_no_done", 32'(dones), 32'd0);
   endtask

   // ---------------- three back-to-back transfers on instance B ----------------
   task automatic run_b_burst();
      logic [7:0] txv [3];
      int   nd, gap, lowlen;
      logic had_low, drop_next;
      txv[0] = 8'h81; txv[1] = 8'h42; txv[2] = 8'hE7;
      @(negedge clk);
      b_if.cpol_i = 1'b0; b_if.cpha_i = 1'b0;
      b_if.tx_data_i = txv[0];
      b_if.start_i = 1'b1;
      sb_b.push_back(txv[0]);
      nd = 0; gap = 0; lowlen = 0; had_low = 1'b0; drop_next = 1'b0;
      for (int k = 0; k < 300 && nd < 3; k++) begin
         @(negedge clk);
         if (drop_next) begin
            b_if.start_i = 1'b0;
            drop_next = 1'b0;
         end
         if (b_cs_n === 1'b0) begin
            if (gap > 0) begin
               check("b_cs_high_gap", 32'(gap), 32'd1);
               gap = 0;
            end
            lowlen++;
            had_low = 1'b1;
         end else begin
            if (lowlen > 0) begin
               check("b_cs_low_cycles", 32'(lowlen), 32'd20);
               lowlen = 0;
            end
            if (had_low) gap++;
         end
         if (b_if.done_o === 1'b1) begin
            nd++;
            if (nd < 3) begin
               b_if.tx_data_i = txv[nd];
               sb_b.push_back(txv[nd]);
            end
            if (nd == 2) drop_next = 1'b1;
         end
      end
      b_if.start_i = 1'b0;
      check("b_done_count", 32'(nd), 32'd3);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0;
      a_if.start_i = 1'b0; a_if.cpol_i = 1'b0; a_if.cpha_i = 1'b0; a_if.tx_data_i = 8'h00;
      b_if.start_i = 1'b0; b_if.cpol_i = 1'b0; b_if.cpha_i = 1'b0; b_if.tx_data_i = 8'h00;
`ifdef SPI_LSB_FIRST_EN
      a_if.lsb_first_i = 1'b0;
      b_if.lsb_first_i = 1'b0;
`endif
      sel_loop = 1'b1; s_word = 8'h00; cur_cpha = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_cs_n", 32'(a_cs_n), 32'd1);
      check("reset_sclk", 32'(a_sclk), 32'd0);
      check("reset_mosi", 32'(a_mosi), 32'd0);
      check("reset_busy", 32'(a_if.busy_o), 32'd0);
      check("reset_done", 32'(a_if.done_o), 32'd0);
      check("reset_rx_data", 32'(a_if.rx_data_o), 32'd0);
      rst_n = 1'b1;

      run_a(1'b0, 1'b0, 8'hA5, 1'b1, 8'h00, 8'hA5, 8'hA5, 0, "mode0_loop");
      run_a(1'b0, 1'b1, 8'h3C, 1'b0, 8'hC3, 8'hC3, 8'h3C, 0, "mode1");
      run_a(1'b1, 1'b0, 8'h3C, 1'b0, 8'hC3, 8'hC3, 8'h3C, 0, "mode2");
      run_a(1'b1, 1'b1, 8'h3C, 1'b0, 8'hC3, 8'hC3, 8'h3C, 0, "mode3");
      run_a(1'b0, 1'b0, 8'h5A, 1'b1, 8'h00, 8'h5A, 8'h5A, 10, "start_in_xfer");
      run_reset_abort();
      run_a(1'b0, 1'b0, 8'h3C, 1'b1, 8'h00, 8'h3C, 8'h3C, 0, "after_reset");
      run_b_burst();
`ifdef SPI_LSB_FIRST_EN
      a_if.lsb_first_i = 1'b1;
      run_a(1'b0, 1'b0, 8'h01, 1'b1, 8'h00, 8'h01, 8'h80, 0, "lsb_first");
      a_if.lsb_first_i = 1'b0;
`endif
      repeat (5) @(negedge clk);
      check("a_scoreboard_empty", 32'(sb_a.size()), 32'd0);
      check("b_scoreboard_empty", 32'(sb_b.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
